// File: rtl/moore_seq_detector.sv
// moore_seq_detector
// Moore-style serial sequence detector for a programmable pattern of
// SEQ_LEN bits (PATTERN[SEQ_LEN-1] is received first). The state is the
// length of the longest matched pattern prefix. The transition table is built
// at elaboration time from the KMP failure rule. OVERLAP selects overlapping
// (1) or non-overlapping (0) detection.
// Optional feature macro: MOORE_SEQDET_CNT_EN adds a saturating detection
// counter (match_cnt / cnt_sat). Without it both ports are tied to zero.
module moore_seq_detector #(
  parameter int          SEQ_LEN = 4,
  parameter logic [31:0] PATTERN = 32'b1011,
  parameter bit          OVERLAP = 1'b0,
  parameter int          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             in,
  input  logic             in_valid,
  input  logic             clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  // State width covers 0..SEQ_LEN. The table is padded to a power of two so
  // that any state code can index it; unreachable codes fall back to 0.
  localparam int SW      = (SEQ_LEN < 2) ? 1 : $clog2(SEQ_LEN + 1);
  localparam int TAB_N   = 1 << SW;

  typedef logic [SW-1:0] state_t;

  localparam state_t FULL_ST = SW'(SEQ_LEN);

  // Pattern bit in arrival order: index 0 is the first bit received.
  function automatic logic pat_bit(input int idx);
    logic [31:0] shifted;
    shifted = PATTERN >> (SEQ_LEN - 1 - idx);
    return shifted[0];
  endfunction

  // Next state from state s on input bit b: longest suffix of
  // (matched prefix, b) that is also a pattern prefix. In non-overlapping
  // mode the full-match state discards its history and restarts.
  function automatic int calc_next(input int s, input logic b);
    int   best;
    int   pos;
    logic ok;
    logic tbit;
    best = 0;
    if ((s == SEQ_LEN) && !OVERLAP) begin
      best = (b == pat_bit(0)) ? 1 : 0;
    end else begin
      for (int k = 1; k <= SEQ_LEN; k++) begin
        if (k <= s + 1) begin
          ok = 1'b1;
          for (int j = 0; j < k; j++) begin
            pos  = s + 1 - k + j;
            tbit = (pos < s) ? pat_bit(pos) : b;
            if (tbit != pat_bit(j)) begin
              ok = 1'b0;
            end
          end
          if (ok) begin
            best = k;
          end
        end
      end
    end
    return best;
  endfunction

  state_t tab0_s [TAB_N];
  state_t tab1_s [TAB_N];

  for (genvar g = 0; g < TAB_N; g++) begin : g_tab
    if (g <= SEQ_LEN) begin : g_live
      localparam int NXT0 = calc_next(g, 1'b0);
      localparam int NXT1 = calc_next(g, 1'b1);
      assign tab0_s[g] = SW'(NXT0);
      assign tab1_s[g] = SW'(NXT1);
    end else begin : g_pad
      assign tab0_s[g] = '0;
      assign tab1_s[g] = '0;
    end
  end

  state_t state_r;
  state_t nxt_s;
  logic   det_s;
  logic   out_r;

  // Table lookup of the next state and the detection decode for this sample.
  always_comb begin
    nxt_s = in ? tab1_s[state_r] : tab0_s[state_r];
    det_s = (nxt_s == FULL_ST);
  end

  // Matching FSM with registered detect flag; clr beats in_valid.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_r <= '0;
      out_r   <= 1'b0;
    end else if (clr) begin
      state_r <= '0;
      out_r   <= 1'b0;
    end else if (in_valid) begin
      state_r <= nxt_s;
      out_r   <= det_s;
    end else begin
      state_r <= state_r;
      out_r   <= out_r;
    end
  end

  assign out = out_r;

`ifdef MOORE_SEQDET_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;
  logic             sat_r;

  // Saturating detection counter; sat flag is set together with the last step.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cnt_r <= '0;
      sat_r <= 1'b0;
    end else if (clr) begin
      cnt_r <= '0;
      sat_r <= 1'b0;
    end else if (in_valid && det_s && !sat_r) begin
      cnt_r <= cnt_r + CNT_W'(1);
      sat_r <= ((cnt_r + CNT_W'(1)) == CNT_MAX);
    end else begin
      cnt_r <= cnt_r;
      sat_r <= sat_r;
    end
  end

  assign match_cnt = cnt_r;
  assign cnt_sat   = sat_r;
`else
  assign match_cnt = '0;
  assign cnt_sat   = 1'b0;
`endif

endmodule

// File: doc/moore_seq_detector.md
# moore_seq_detector

Parametrised Moore-style serial sequence detector: samples one bit per qualified clock, tracks the longest matched prefix of a programmable pattern, and raises `out` while the full pattern has just been matched. Supports overlapping and non-overlapping detection selected by parameter, plus a synchronous clear and an optional saturating detection counter. It is the generalised successor to the fixed-pattern non-overlapping detector and sits directly on a serial bit stream in front of framing and control logic.

## Interface
- `SEQ_LEN`, 4: pattern length in bits; legal range 1..32.
- `PATTERN`, 32'b1011: pattern bits in `PATTERN[SEQ_LEN-1:0]`. `PATTERN[SEQ_LEN-1]` is the first bit received. Upper bits are ignored.
- `OVERLAP`, 0: 1 = overlapping detection, 0 = non-overlapping detection.
- `CNT_W`, 8: width of the detection counter.
- `clk`  in  1  clock; all state changes on the rising edge.
- `arstn`  in  1  reset; asynchronous, active-low.
- `in`  in  1  serial data bit.
- `in_valid`  in  1  `in` is sampled only when this is 1.
- `clr`  in  1  synchronous clear of state, `out` and counter.
- `out`  out  1  registered detect flag.
- `match_cnt`  out  CNT_W  number of detections, saturating.
- `cnt_sat`  out  1  `match_cnt` has reached all-ones.

## Operation
- State S = number of pattern bits currently matched, 0..SEQ_LEN. This gives SEQ_LEN+1 states. S0 is the reset state.
- When `in_valid`=1, the next state is the length of the longest suffix of (matched prefix followed by `in`) that is also a prefix of the pattern. This is KMP failure semantics and is computed at elaboration time.
- From S=SEQ_LEN:
  - With OVERLAP=1, use the same suffix rule on the full pattern followed by `in`. The state S=SEQ_LEN can return to itself, for example with pattern 1111.
  - With OVERLAP=0, the matched history is discarded. Next state is 1 if `in`==`PATTERN[SEQ_LEN-1]`, else 0.
- When `in_valid`=0, the state holds and `out` holds.
- `out` = 1 exactly while the state is SEQ_LEN. It is a flop loaded with (next_state==SEQ_LEN), so it has no decode glitches.
- Detection event: any valid-sample transition whose next state is SEQ_LEN, including the SEQ_LEN→SEQ_LEN self-loop.
- Each detection event increments `match_cnt` by 1. At all-ones the counter holds and `cnt_sat`=1.
- `clr`=1 forces state to 0, `out` to 0, `match_cnt` to 0 and `cnt_sat` to 0. `clr` has priority over `in_valid`, and the bit sampled in that cycle is discarded.

## Timing
- Reset values (`arstn`=0, asynchronous): state 0, `out`=0, `match_cnt`=0, `cnt_sat`=0.
- Deassertion of `arstn` is synchronised externally. The first sample is taken at the first rising edge with `arstn`=1.
- Latency: if the last pattern bit is sampled at edge N, then `out`=1 and `match_cnt` is updated after edge N. `out` stays 1 until the next edge with `in_valid`=1 leaves S=SEQ_LEN.
- Reset mid-stream: all progress is lost immediately, with no wait for a clock edge.
- `clr` and a detection in the same cycle: `clr` wins, giving `out`=0 and count 0.
- SEQ_LEN=1: every matching valid bit is a detection. OVERLAP then has no effect.

## Configuration
- Macro `MOORE_SEQDET_CNT_EN`.
- Defined: `match_cnt` and `cnt_sat` are implemented as described above.
- Undefined: the counter logic is removed. The `match_cnt` and `cnt_sat` ports remain and are tied to 0. `out` behaviour is unchanged.

## Test plan
- Reset, overlap mode: PATTERN=1011, OVERLAP=1, `in_valid`=1, stream 1,0,1,1,0,1,1 → `out` high after bit 4 and after bit 7, low after bits 5 and 6; `match_cnt`=2.
- Reset, non-overlap mode: the same stream with OVERLAP=0 → `out` high only after bit 4; `match_cnt`=1.
- Self-loop: PATTERN=1111, six 1s.
  - OVERLAP=1 → `out` high after bits 4, 5 and 6; count 3.
  - OVERLAP=0 → `out` high after bit 4 only; count 1. Two further 1s give a detection after bit 8.
- Valid gating: drive 1,0,1 then `in_valid`=0 for 5 cycles with `in` toggling, then 1 → detection after the 4th valid bit. `out` stays high through a later `in_valid`=0 gap.
- Clear and reset: assert `clr` on the cycle the final 1 of 1011 is sampled → `out`=0, count 0. Pulse `arstn` low mid-pattern between edges → outputs 0 immediately, and the next 1011 is detected normally.
- Saturation: CNT_W=2, five detections → `match_cnt`=3 and `cnt_sat`=1 after the 3rd detection, then held. With `MOORE_SEQDET_CNT_EN` undefined → both ports read 0.
